// File: rtl/uart_frame_arbiter_if.sv
// Two-channel 24-bit word handshake plus the uarttx byte port and frame status.
// Latency: none, wires only.
// Backpressure: req held until ack; uart_idle high holds off byte strobes.
interface uart_frame_arbiter_if;
  logic        req0;
  logic [23:0] data0;
  logic        ack0;
  logic        req1;
  logic [23:0] data1;
  logic        ack1;
  logic        uart_idle;
  logic [7:0]  tx_data;
  logic        wrsig;
  logic        busy;
  logic        grant;
  logic [15:0] frame_cnt;

  // Word sources and the uarttx model drive this side.
  modport master (
    output req0, data0, req1, data1, uart_idle,
    input  ack0, ack1, tx_data, wrsig, busy, grant, frame_cnt
  );

  // The arbiter itself.
  modport slave (
    input  req0, data0, req1, data1, uart_idle,
    output ack0, ack1, tx_data, wrsig, busy, grant, frame_cnt
  );
endinterface

// File: rtl/uart_frame_arbiter.sv
// Round-robin arbiter framing 24-bit words from two sources into header+3 byte uarttx frames.
// Latency: ack to first wrsig 2 cycles; wrsig-to-wrsig at least GAP+2 cycles.
// Backpressure: req held until ack; uart_idle high stalls the strobe indefinitely (optional UART_FRAME_CHECKSUM_EN adds an XOR byte).
module uart_frame_arbiter #(
  parameter logic [7:0]  HDR0 = 8'h55,
  parameter logic [7:0]  HDR1 = 8'hAA,
  parameter int unsigned GAP  = 170
) (
  input  logic                 UART_CLK,
  input  logic                 rst,
  uart_frame_arbiter_if.slave  bus
);

`ifdef UART_FRAME_CHECKSUM_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif
  localparam logic [15:0] GAP_CNT = 16'(GAP);

  typedef enum logic [1:0] {ARB, LOAD, STROBE, WAIT} state_t;

  state_t      state_q;
  state_t      state_nxt;
  logic        take;
  logic        pick;

  logic [31:0] shreg_q;
  logic [2:0]  idx_q;
  logic [15:0] timer_q;
  logic        rr_last_q;
  // No tie-break history until a frame has completed, so ch0 wins the first contest.
  logic        rr_hist_q;
  logic        ack0_q;
  logic        ack1_q;
  logic        wrsig_q;
  logic        busy_q;
  logic        grant_q;
  logic [7:0]  tx_data_q;
  logic [15:0] frame_cnt_q;
`ifdef UART_FRAME_CHECKSUM_EN
  logic [7:0]  csum_q;
`endif

  // Next state and arbitration choice; requests only matter in ARB.
  always_comb begin
    state_nxt = state_q;
    take      = 1'b0;
    pick      = 1'b0;
    case (state_q)
      ARB: begin
        if (bus.req0 || bus.req1) begin
          take      = 1'b1;
          if (bus.req0 && bus.req1) pick = rr_hist_q ? ~rr_last_q : 1'b0;
          else                      pick = bus.req1;
          state_nxt = LOAD;
        end
      end
      LOAD:    state_nxt = STROBE;
      STROBE:  if (!bus.uart_idle) state_nxt = WAIT;
      WAIT: begin
        if (timer_q == GAP_CNT) state_nxt = (idx_q == LAST_IDX) ? ARB : LOAD;
      end
      default: state_nxt = ARB;
    endcase
  end

  // State register; reset abandons any frame in flight.
  always_ff @(posedge UART_CLK or negedge rst) begin
    if (!rst) state_q <= ARB;
    else      state_q <= state_nxt;
  end

  // Datapath: word latch, byte shifting, gap timer, status and strobes.
  always_ff @(posedge UART_CLK or negedge rst) begin
    if (!rst) begin
      shreg_q     <= 32'h0;
      idx_q       <= 3'd0;
      timer_q     <= 16'h0;
      rr_last_q   <= 1'b0;
      rr_hist_q   <= 1'b0;
      ack0_q      <= 1'b0;
      ack1_q      <= 1'b0;
      wrsig_q     <= 1'b0;
      busy_q      <= 1'b0;
      grant_q     <= 1'b0;
      tx_data_q   <= 8'h00;
      frame_cnt_q <= 16'h0;
`ifdef UART_FRAME_CHECKSUM_EN
      csum_q      <= 8'h00;
`endif
    end else begin
      ack0_q  <= 1'b0;
      ack1_q  <= 1'b0;
      wrsig_q <= 1'b0;
      case (state_q)
        ARB: begin
          if (take) begin
            ack0_q  <= ~pick;
            ack1_q  <= pick;
            shreg_q <= pick ? {HDR1, bus.data1} : {HDR0, bus.data0};
            busy_q  <= 1'b1;
            grant_q <= pick;
            idx_q   <= 3'd0;
`ifdef UART_FRAME_CHECKSUM_EN
            csum_q  <= 8'h00;
`endif
          end
        end
        LOAD: begin
`ifdef UART_FRAME_CHECKSUM_EN
          if (idx_q == LAST_IDX) begin
            tx_data_q <= csum_q;
          end else begin
            tx_data_q <= shreg_q[31:24];
            csum_q    <= csum_q ^ shreg_q[31:24];
          end
`else
          tx_data_q <= shreg_q[31:24];
`endif
          shreg_q <= {shreg_q[23:0], 8'h00};
        end
        STROBE: begin
          if (!bus.uart_idle) begin
            wrsig_q <= 1'b1;
            timer_q <= 16'd1;
          end
        end
        WAIT: begin
          if (timer_q == GAP_CNT) begin
            if (idx_q == LAST_IDX) begin
              frame_cnt_q <= frame_cnt_q + 16'd1;
              busy_q      <= 1'b0;
              rr_last_q   <= grant_q;
              rr_hist_q   <= 1'b1;
            end else begin
              idx_q <= idx_q + 3'd1;
            end
          end else if (timer_q != 16'hFFFF) begin
            timer_q <= timer_q + 16'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.ack0      = ack0_q;
  assign bus.ack1      = ack1_q;
  assign bus.wrsig     = wrsig_q;
  assign bus.busy      = busy_q;
  assign bus.grant     = grant_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.frame_cnt = frame_cnt_q;

endmodule
